// File: rtl/spi_pkg.sv
// spi_pkg: shared state encoding and widths for the SPI master
package spi_pkg;
   localparam logic [2:0] IDLE = 3'd0, SETUP = 3'd1, HIGH = 3'd2, LOW = 3'd3, HOLD = 3'd4, DONE = 3'd5;
   localparam int DATA_W = 8;
   localparam int CNT_W = 4;
endpackage

// File: rtl/spi_clk_tick.sv
// spi_clk_tick: half-period divider, cleared while disabled, one-clk tick on terminal count
module spi_clk_tick #(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic reset_n,
   input  logic en,
   output logic tick
);
   localparam logic [7:0] TC = 8'(CLK_DIV - 1);
   logic [7:0] cnt;
   assign tick = en && cnt == TC;
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) cnt <= '0;
      else cnt <= (!en || tick) ? '0 : cnt + 8'd1;
endmodule

// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: 8-bit LSB-first SPI master with start/busy/done host handshake and registered line outputs
module spi_master_ctrl
   import spi_pkg::*;
#(
   parameter int CLK_DIV = 4,
   parameter int EXTRA_SCLK = 0
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [DATA_W-1:0] dataToTransmit,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] dataRecieved,
   output logic              sclk,
   output logic              ss,
   output logic              MOSI,
   input  logic              MISO
);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W + EXTRA_SCLK - 1);
   localparam logic [CNT_W-1:0] NBITS = CNT_W'(DATA_W);
   logic [2:0] state, next_state;
   logic [DATA_W-1:0] tx, rx;
   logic [CNT_W-1:0] pulses;
   logic tick, run, accept, sample;
   logic sclk_d, ss_d, mosi_d, busy_d, done_d;
   assign run = state inside {SETUP, HIGH, LOW, HOLD};
   assign accept = (state == IDLE || state == DONE) && start;
   spi_clk_tick #(.CLK_DIV(CLK_DIV)) u_tick (
      .clk(clk),
      .reset_n(reset_n),
      .en(run),
      .tick(tick)
   );
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) state <= IDLE;
      else state <= next_state;
   // a request held through DONE is taken at once so ss shows high for a single clk
   always_comb begin
      next_state = state;
      case (state)
         IDLE, DONE: next_state = start ? SETUP : IDLE;
         SETUP: next_state = tick ? HIGH : SETUP;
         HIGH: next_state = tick ? LOW : HIGH;
         LOW: next_state = tick ? ((pulses < LAST) ? HIGH : HOLD) : LOW;
         HOLD: next_state = tick ? DONE : HOLD;
         default: next_state = IDLE;
      endcase
   end
   always_comb begin
      sclk_d = state == HIGH;
      ss_d = !run;
      mosi_d = (state inside {SETUP, HIGH, LOW}) ? tx[0] : 1'b1;
      busy_d = run;
      done_d = state == DONE;
   end
   // MISO is taken one clk after the HIGH tick, i.e. on the edge where the sclk pin falls
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         tx <= '1;
         rx <= '0;
         pulses <= '0;
         sample <= 1'b0;
      end else begin
         sample <= state == HIGH && tick && pulses < NBITS;
         if (sample) rx <= {MISO, rx[DATA_W-1:1]};
         if (accept) begin
            tx <= dataToTransmit;
            pulses <= '0;
         end else if (state == HIGH && tick) tx <= {1'b1, tx[DATA_W-1:1]};
         else if (state == LOW && tick && pulses < LAST) pulses <= pulses + 1'b1;
      end
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         sclk <= 1'b0;
         ss <= 1'b1;
         MOSI <= 1'b1;
         busy <= 1'b0;
         done <= 1'b0;
         dataRecieved <= '0;
      end else begin
         sclk <= sclk_d;
         ss <= ss_d;
         MOSI <= mosi_d;
         busy <= busy_d;
         done <= done_d;
         if (state == DONE) dataRecieved <= rx;
      end
endmodule
